scarv_cop_mul_arbiter: RTL
==========================

Name: scarv_cop_mul_arbiter

Overview:
- Shares one packed multiplier (scarv_cop_palu_multiplier) between two requesters inside the coprocessor: port 0 is the PALU instruction path, port 1 is the crypto/bignum helper path.
- Arbitrates round-robin and latches the operands of the granted request.
- Sequences the multiplier start/done handshake, returns a registered result to the owning requester, and aborts hung operations through a watchdog.

Parameters:
- TIMEOUT, 64, cycles in BUSY without mul_done before the operation is aborted with an error; legal range 2..255.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  asynchronous active-low reset
- rq0_req  in  1  port 0 request; held until rq0_gnt
- rq0_a, rq0_b  in  32 each  port 0 operands
- rq0_pw  in  3  port 0 pack width
- rq0_hi, rq0_ncarry  in  1 each  port 0 high-half select, carry-suppress
- rq0_gnt  out  1  port 0 request accepted this cycle
- rs0_valid  out  1  port 0 response pulse
- rs0_result  out  32  port 0 result
- rs0_err  out  1  port 0 timeout flag, valid with rs0_valid
- rq1_* / rs1_*  same set as port 0, for port 1
- mul_start  out  1  multiplier start
- mul_a, mul_b  out  32 each  latched operands
- mul_pw  out  3  latched pack width
- mul_hi, mul_ncarry  out  1 each  latched flags
- mul_done  in  1  multiplier done
- mul_result  in  32  multiplier result
- busy  out  1  high while in BUSY

Behaviour:
- Reset (async, g_resetn low):
  - state=IDLE; all outputs 0 (gnt, rs*_valid, rs*_err, rs*_result, mul_* operands, mul_start, busy).
  - last_owner=1, so port 0 wins the first tie.
  - Reset mid-operation abandons the job silently: no response is issued.
- States: IDLE and BUSY.
- IDLE:
  - If any rqX_req is high, raise rqX_gnt combinationally this cycle.
  - Tie: the port that is not last_owner wins. The loser's gnt stays 0 and it keeps requesting.
  - At the clock edge: latch the winner's operands into mul_*, set owner=X, last_owner=X, clear the timeout counter, go to BUSY.
  - A requester may change its operands or drop req in the cycle after gnt.
- BUSY:
  - mul_start=1 and mul_* stable throughout; busy=1; no gnt to either port.
  - The counter increments every cycle.
  - If mul_done=1: capture mul_result into rs[owner]_result, pulse rs[owner]_valid=1 with rs[owner]_err=0 in the next cycle, go to IDLE.
  - Else if counter reaches TIMEOUT-1: rs[owner]_valid=1, err=1, result=0 in the next cycle, go to IDLE.
  - mul_done takes priority over the timeout in the same cycle.
- Multiplier contract: mul_start is low for at least one cycle between operations. That low cycle re-initialises the multiplier, which makes aborts safe.
- Latency:
  - Request accepted at cycle N; mul_start high N+1..M, where M is the cycle mul_done is seen.
  - rsX_valid at M+1.
  - Earliest next grant is M+1 (IDLE). mul_start is low at M+1, so the next start is at M+2 at the earliest.
- rsX_valid is a single-cycle pulse.
- rsX_result holds its value until the next response to the same port. The other port's result register is untouched.
- mul_done outside BUSY is ignored.
- Back-to-back requests with both ports always requesting alternate strictly 0,1,0,1.

Decomposition:
- Shared package scarv_cop_mul_pkg holds:
  - state encodings (ST_IDLE, ST_BUSY)
  - the pack-width encodings (PW_32, PW_16, PW_8, PW_4, PW_2)
  - the default TIMEOUT
- One natural sub-module: scarv_cop_rr_arb2, a 2-way round-robin arbiter with req[1:0], enable and last_owner in, and a one-hot gnt[1:0] out.
- The operand latch, FSM and watchdog stay in the top module.

Test Plan:
- Single request: rq0 with a=0x0000_0003, b=0x0000_0005, pw=PW_32, hi=0; model done 4 cycles after start with result 0x0000_000F -> rq0_gnt at N, mul_start high N+1..N+4, rs0_valid at N+5 with result 0x0000_000F, err=0, rs1_valid stays 0.
- Tie after reset: rq0 and rq1 asserted together -> port 0 granted first and port 1 served next; with both held high, grants alternate 0,1,0,1 over 4 operations.
- Timeout: TIMEOUT=8 and the model never raises done -> rsX_valid at N+9 with err=1 and result=0; mul_start low the following cycle; the next request is then served normally.
- Done on the final timeout cycle: mul_done=1 exactly when the counter hits TIMEOUT-1 -> err=0 and the result is returned.
- Async reset mid-BUSY: g_resetn pulsed low between clock edges -> mul_start and busy drop immediately with no rs*_valid; after release, rq1 alone is granted with port-0 tie priority restored.
- Result isolation: port 0 returns 0xDEAD_BEEF, then port 1 returns 0x1234_5678 -> rs0_result still reads 0xDEAD_BEEF; a spurious mul_done in IDLE produces no response.

Source files
------------

// File: rtl/scarv_cop_mul_pkg.sv
// Shared encodings for the coprocessor multiplier arbiter: FSM states,
// packed-width codes, and the latched operand bundle.
package scarv_cop_mul_pkg;

    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        PW_32 = 3'b000,
        PW_16 = 3'b001,
        PW_8  = 3'b010,
        PW_4  = 3'b011,
        PW_2  = 3'b100
    } pw_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  pw;
        logic        hi;
        logic        ncarry;
    } mul_op_t;

endpackage

// File: rtl/scarv_cop_mul_arbiter_if.sv
// Bundle of both requester ports plus the shared multiplier handshake.
// slave = arbiter view, master = environment (requesters + multiplier) view.
interface scarv_cop_mul_arbiter_if;
    logic        rq0_req, rq1_req;
    logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b;
    logic [2:0]  rq0_pw, rq1_pw;
    logic        rq0_hi, rq0_ncarry, rq1_hi, rq1_ncarry;
    logic        rq0_gnt, rq1_gnt;
    logic        rs0_valid, rs1_valid;
    logic [31:0] rs0_result, rs1_result;
    logic        rs0_err, rs1_err;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic [2:0]  mul_pw;
    logic        mul_hi, mul_ncarry;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        busy;

    modport slave (
        input  rq0_req, rq0_a, rq0_b, rq0_pw, rq0_hi, rq0_ncarry,
        input  rq1_req, rq1_a, rq1_b, rq1_pw, rq1_hi, rq1_ncarry,
        output rq0_gnt, rq1_gnt,
        output rs0_valid, rs0_result, rs0_err,
        output rs1_valid, rs1_result, rs1_err,
        output mul_start, mul_a, mul_b, mul_pw, mul_hi, mul_ncarry,
        input  mul_done, mul_result,
        output busy
    );

    modport master (
        output rq0_req, rq0_a, rq0_b, rq0_pw, rq0_hi, rq0_ncarry,
        output rq1_req, rq1_a, rq1_b, rq1_pw, rq1_hi, rq1_ncarry,
        input  rq0_gnt, rq1_gnt,
        input  rs0_valid, rs0_result, rs0_err,
        input  rs1_valid, rs1_result, rs1_err,
        input  mul_start, mul_a, mul_b, mul_pw, mul_hi, mul_ncarry,
        output mul_done, mul_result,
        input  busy
    );
endinterface

// File: rtl/scarv_cop_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that did not own the
// previous operation wins. Purely combinational, one-hot output.
module scarv_cop_rr_arb2 (
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       last_owner,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) gnt = last_owner ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end
endmodule

// File: rtl/scarv_cop_mul_arbiter.sv
// Shares one packed multiplier between the PALU path (port 0) and the
// bignum helper path (port 1), with operand latch and watchdog abort.
module scarv_cop_mul_arbiter
    import scarv_cop_mul_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic g_clk,
    input  logic g_resetn,
    scarv_cop_mul_arbiter_if.slave bus
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic             owner, last_owner;
    logic [7:0]       cnt;
    logic [1:0]       req, gnt;
    mul_op_t          op0, op1, op_q;
    logic [1:0]       rs_valid, rs_err;
    logic [1:0][31:0] rs_result;
    logic             mul_start, busy;

    assign req = {bus.rq1_req, bus.rq0_req};
    assign op0 = '{a: bus.rq0_a, b: bus.rq0_b, pw: bus.rq0_pw,
                   hi: bus.rq0_hi, ncarry: bus.rq0_ncarry};
    assign op1 = '{a: bus.rq1_a, b: bus.rq1_b, pw: bus.rq1_pw,
                   hi: bus.rq1_hi, ncarry: bus.rq1_ncarry};

    scarv_cop_rr_arb2 u_arb (
        .req        (req),
        .enable     (state == ST_IDLE),
        .last_owner (last_owner),
        .gnt        (gnt)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            op_q       <= '0;
            rs_valid   <= '0;
            rs_err     <= '0;
            rs_result  <= '0;
            mul_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rs_valid <= '0;
            rs_err   <= '0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        op_q       <= gnt[1] ? op1 : op0;
                        owner      <= gnt[1];
                        last_owner <= gnt[1];
                        cnt        <= '0;
                        mul_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 8'd1;
                    // done wins over an expiring watchdog in the same cycle
                    if (bus.mul_done || cnt == CNT_LAST) begin
                        rs_result[owner] <= bus.mul_done ? bus.mul_result : 32'd0;
                        rs_err[owner]    <= ~bus.mul_done;
                        rs_valid[owner]  <= 1'b1;
                        mul_start        <= 1'b0;
                        busy             <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rq0_gnt    = gnt[0];
    assign bus.rq1_gnt    = gnt[1];
    assign bus.rs0_valid  = rs_valid[0];
    assign bus.rs1_valid  = rs_valid[1];
    assign bus.rs0_err    = rs_err[0];
    assign bus.rs1_err    = rs_err[1];
    assign bus.rs0_result = rs_result[0];
    assign bus.rs1_result = rs_result[1];
    assign bus.mul_start  = mul_start;
    assign bus.mul_a      = op_q.a;
    assign bus.mul_b      = op_q.b;
    assign bus.mul_pw     = op_q.pw;
    assign bus.mul_hi     = op_q.hi;
    assign bus.mul_ncarry = op_q.ncarry;
    assign bus.busy       = busy;
endmodule
